dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter granting a CPU or debug requester single accesses to DMEM,
// with alignment/range checking and CPU load extension.
module dmem_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_op,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic              dm_cs,
  output logic              dm_r,
  output logic              dm_w,
  output logic [1:0]        dm_sel,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic last_grant, who, we, win, w_bad, any_req;
  logic [2:0] op, w_op;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, w_addr, ext;
  always_comb begin
    any_req = cpu_req | dbg_req;
    win = (cpu_req && dbg_req) ? ~last_grant : dbg_req;
    w_op = win ? 3'b100 : cpu_op;
    w_addr = win ? dbg_addr : cpu_addr;
    w_bad = (w_op > 3'd4) || (w_op[2:1] == 2'b01 && w_addr[0]) || (w_op[2] && |w_addr[1:0])
            || |(w_addr >> ADDR_W);
    ext = op == 3'b000 ? {{24{dm_rdata[7]}}, dm_rdata[7:0]} :
          op == 3'b001 ? {24'h0, dm_rdata[7:0]} :
          op == 3'b010 ? {{16{dm_rdata[15]}}, dm_rdata[15:0]} :
          op == 3'b011 ? {16'h0, dm_rdata[15:0]} : dm_rdata;
    state_nx = state == IDLE ? (any_req ? (w_bad ? DONE : ACCESS) : IDLE) :
               state == ACCESS ? DONE : IDLE;
  end
  assign dm_cs    = state == ACCESS;
  assign dm_r     = dm_cs & ~we;
  assign dm_w     = dm_cs & we;
  assign dm_sel   = {op[2], op[2] | op[1]};
  assign dm_addr  = addr;
  assign dm_wdata = wdata;
  assign cpu_done = state == DONE && !who;
  assign dbg_done = state == DONE && who;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      who <= 1'b0;
      we <= 1'b0;
      op <= 3'b000;
      addr <= '0;
      wdata <= '0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
      dbg_rdata <= '0;
      dbg_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        last_grant <= win;
        who <= win;
        we <= win ? dbg_we : cpu_we;
        op <= w_op;
        addr <= w_addr[ADDR_W-1:0];
        wdata <= win ? dbg_wdata : cpu_wdata;
        // illegal requests skip ACCESS, so their result is fixed here
        if (w_bad && win) begin
          dbg_rdata <= '0;
          dbg_err <= 1'b1;
        end else if (w_bad) begin
          cpu_rdata <= '0;
          cpu_err <= 1'b1;
        end
      end
      if (state == ACCESS && who) begin
        dbg_rdata <= we ? 32'h0 : ext;
        dbg_err <= 1'b0;
      end else if (state == ACCESS) begin
        cpu_rdata <= we ? 32'h0 : ext;
        cpu_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed scoreboard bench for dmem_arbiter against a
// byte-array reference memory model.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, cpu_done, cpu_err;
  logic [2:0] cpu_op;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic dbg_req, dbg_we, dbg_done, dbg_err;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic dm_cs, dm_r, dm_w;
  logic [1:0] dm_sel;
  logic [AW-1:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic [32:0] cpu_q[$];
  logic [32:0] dbg_q[$];
  int log_q[$];
  logic [31:0] cpu_hold_rd = 0, dbg_hold_rd = 0;
  logic cpu_hold_err = 0, dbg_hold_err = 0;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DMEM environment: combinational zero-filled read, write on the edge ending ACCESS
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (dm_cs && dm_w) begin
      mem[dm_addr] <= dm_wdata[7:0];
      if (dm_sel != 2'b00) mem[dm_addr + AW'(1)] <= dm_wdata[15:8];
      if (dm_sel == 2'b11) begin
        mem[dm_addr + AW'(2)] <= dm_wdata[23:16];
        mem[dm_addr + AW'(3)] <= dm_wdata[31:24];
      end
    end
  end
  always_comb begin
    dm_rdata = {24'h0, mem[dm_addr]};
    if (dm_sel != 2'b00) dm_rdata[15:8] = mem[dm_addr + AW'(1)];
    if (dm_sel == 2'b11) begin
      dm_rdata[23:16] = mem[dm_addr + AW'(2)];
      dm_rdata[31:24] = mem[dm_addr + AW'(3)];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference: access size from op, legality by divisibility/range, data by byte arithmetic
  task automatic push_exp(input logic who, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic ill, output int size);
    logic [31:0] v;
    if (who) op = 3'b100;
    size = op[2] ? 4 : op[1] ? 2 : 1;
    ill = (op > 3'd4) || (addr >= DEPTH) || (addr % size != 0);
    v = 0;
    if (!ill && we) begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
    end else if (!ill) begin
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (!op[0] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFFFFFF << (8 * size));
    end
    if (who) dbg_q.push_back({v, ill});
    else cpu_q.push_back({v, ill});
  endtask

  task automatic txn(input logic who, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic ill, seen;
    int size, n, ncs;
    push_exp(who, we, op, addr, wdata, ill, size);
    n = 0;
    ncs = 0;
    seen = 0;
    @(negedge clk);
    if (who) begin
      dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_op = op; cpu_addr = addr; cpu_wdata = wdata;
    end
    while (!seen && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (dm_cs) begin
        ncs++;
        chk("dm_sel", 32'(dm_sel), size == 1 ? 0 : size == 2 ? 1 : 3);
        chk("dm_addr", 32'(dm_addr), addr & (DEPTH - 1));
        chk("dm_w", 32'(dm_w), 32'(we));
        chk("dm_r", 32'(dm_r), 32'(!we));
        if (we) chk("dm_wdata", dm_wdata, wdata);
      end
      seen = who ? dbg_done : cpu_done;
    end
    cpu_req = 0;
    dbg_req = 0;
    chk("done_latency", n, ill ? 1 : 2);
    chk("dm_cs_cycles", ncs, ill ? 0 : 1);
    @(posedge clk);
  endtask

  // Monitor: pops expected responses on each done and checks held outputs otherwise
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      cpu_hold_rd <= 0; cpu_hold_err <= 0; dbg_hold_rd <= 0; dbg_hold_err <= 0;
    end else begin
      if (cpu_done && dbg_done) chk("both_done", 32'(dbg_done), 0);
      if (cpu_done) begin
        log_q.push_back(cyc * 2);
        if (cpu_q.size() == 0) chk("cpu_unexpected_done", 32'(cpu_done), 0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_rdata", cpu_rdata, e[32:1]);
          chk("cpu_err", 32'(cpu_err), 32'(e[0]));
          cpu_hold_rd <= e[32:1];
          cpu_hold_err <= e[0];
        end
      end else begin
        chk("cpu_rdata_hold", cpu_rdata, cpu_hold_rd);
        chk("cpu_err_hold", 32'(cpu_err), 32'(cpu_hold_err));
      end
      if (dbg_done) begin
        log_q.push_back(cyc * 2 + 1);
        if (dbg_q.size() == 0) chk("dbg_unexpected_done", 32'(dbg_done), 0);
        else begin
          e = dbg_q.pop_front();
          chk("dbg_rdata", dbg_rdata, e[32:1]);
          chk("dbg_err", 32'(dbg_err), 32'(e[0]));
          dbg_hold_rd <= e[32:1];
          dbg_hold_err <= e[0];
        end
      end else begin
        chk("dbg_rdata_hold", dbg_rdata, dbg_hold_rd);
        chk("dbg_err_hold", 32'(dbg_err), 32'(dbg_hold_err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic ill, got;
    int size, n, cnt;
    rst = 1;
    cpu_req = 1; cpu_we = 1; cpu_op = 3'b100; cpu_addr = 32'h10; cpu_wdata = 32'h12345678;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10; dbg_wdata = 0;
    clear_ref();
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 1, 3'b100, 32'h10, 32'h12345678, ill, size);
      push_exp(1, 0, 3'b100, 32'h10, 0, ill, size);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_done", 32'(cpu_done), 0);
    chk("rst_dbg_done", 32'(dbg_done), 0);
    chk("rst_cpu_err", 32'(cpu_err), 0);
    chk("rst_dbg_err", 32'(dbg_err), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_dm_ctl", {29'h0, dm_cs, dm_r, dm_w}, 0);
    chk("rst_dm_sel", 32'(dm_sel), 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    #1 rst = 0;
    n = 0;
    cnt = 0;
    log_q.delete();
    while (cnt < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (cpu_done || dbg_done) cnt++;
    end
    cpu_req = 0;
    dbg_req = 0;
    chk("alt_done_count", cnt, 4);
    @(negedge clk); #1;
    chk("alt_log_size", log_q.size(), 4);
    for (int i = 0; i < log_q.size() && i < 4; i++) begin
      chk("alt_winner", log_q[i] % 2, i % 2);
      if (i > 0) chk("alt_gap", log_q[i] / 2 - log_q[i - 1] / 2, 3);
    end
    @(posedge clk);
    txn(0, 1, 3'b100, 32'h10, 32'h12345678);
    txn(0, 0, 3'b100, 32'h10, 0);
    txn(0, 1, 3'b000, 32'h21, 32'h000000F0);
    txn(0, 0, 3'b000, 32'h21, 0);
    txn(0, 0, 3'b001, 32'h21, 0);
    txn(0, 0, 3'b010, 32'h20, 0);
    txn(0, 0, 3'b011, 32'h20, 0);
    txn(0, 0, 3'b010, 32'h13, 0);
    txn(0, 0, 3'b100, 32'h02, 0);
    txn(1, 0, 3'b100, 32'h1 << AW, 0);
    txn(0, 0, 3'b101, 32'h10, 0);
    txn(1, 1, 3'b100, 32'h1FC, 32'h8BADF00D);
    txn(0, 0, 3'b010, 32'h1FE, 0);
    txn(1, 0, 3'b100, 32'h1FC, 0);
    for (int k = 0; k < 200; k++) begin
      logic who, w;
      logic [2:0] o;
      logic [31:0] a;
      int sz;
      who = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      o = who ? 3'b100 : 3'($urandom_range(0, 5));
      a = $urandom_range(0, 63);
      sz = o[2] ? 4 : o[1] ? 2 : 1;
      if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(AW, 31));
      txn(who, w, o, a, $urandom);
    end
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_op = 3'b100; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("abort_cs", 32'(dm_cs), 1);
    chk("abort_w", 32'(dm_w), 1);
    #1 rst = 1;
    #1;
    chk("abort_dm_ctl", {29'h0, dm_cs, dm_r, dm_w}, 0);
    chk("abort_dm_addr", 32'(dm_addr), 0);
    chk("abort_dm_wdata", dm_wdata, 0);
    chk("abort_cpu_done", 32'(cpu_done), 0);
    cpu_we = 0; cpu_op = 3'b101;
    dbg_req = 1; dbg_we = 0; dbg_addr = 0;
    clear_ref();
    push_exp(0, 0, 3'b101, 32'h30, 0, ill, size);
    @(posedge clk); #1;
    chk("abort_no_done", {30'h0, cpu_done, dbg_done}, 0);
    #1 rst = 0;
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      @(posedge clk); #1;
      n++;
      got = cpu_done | dbg_done;
    end
    chk("tie_cpu_wins", 32'(cpu_done), 1);
    chk("tie_dbg_waits", 32'(dbg_done), 0);
    chk("tie_latency", n, 1);
    cpu_req = 0;
    dbg_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dbg_q_drained", dbg_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
